// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: processes DIGIT bits per clock, LSB digit first,
// with the inter-digit carry held in a register and a start/busy/done handshake.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH == 0 || DIGIT == 0 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_adder: WIDTH must be a non-zero multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             accept;
  logic             last;

  // Ripple chain of DIGIT full-adder cells over the low digit of the operand shifters
  always_comb begin : digit_adder
    logic c;
    c       = carry_q;
    dig_sum = '0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      dig_sum[i] = a_q[i] ^ b_q[i] ^ c;
      c          = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
    dig_cout = c;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    accept   = 1'b0;
    last     = (cnt_q == CW'(N - 1));

    case (state_q)
      S_IDLE: begin
        accept = start_i;
      end
      S_RUN: begin
        // Operands shift down so the active digit is always at bit 0; results fill from the top
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        shadow_d = (shadow_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
        carry_d  = dig_cout;
        cnt_d    = cnt_q + CW'(1);
        if (last) begin
          sum_d   = shadow_d;
          cout_d  = dig_cout;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
          accept  = start_i;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        accept  = start_i;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Subtraction becomes a + ~b + ~cin by inverting b and the carry at load time
    if (accept) begin
      a_d     = a_i;
      b_d     = b_i ^ {WIDTH{sub_i}};
      carry_d = cin_i ^ sub_i;
      cnt_d   = '0;
      busy_d  = 1'b1;
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      shadow_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: six width/digit configurations driven in parallel and checked
// every cycle against a transaction-level arithmetic model, plus literal directed results.
module tb_serial_adder;

  localparam int NI = 6;
  localparam int CFG_W [NI] = '{8, 8, 8, 4, 4, 4};
  localparam int CFG_D [NI] = '{2, 1, 8, 1, 2, 4};

  logic       clk = 1'b0;
  logic       rst, start, cin, sub;
  logic [7:0] a, b;

  wire        busy [NI];
  wire        done [NI];
  wire        cout [NI];
  wire  [7:0] sum  [NI];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  int lat [NI];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int W = CFG_W[g];
      localparam int D = CFG_D[g];
      logic [W-1:0] s;
      logic         bz, dn, co;
      serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .start_i(start),
        .a_i    (a[W-1:0]),
        .b_i    (b[W-1:0]),
        .cin_i  (cin),
        .sub_i  (sub),
        .busy_o (bz),
        .done_o (dn),
        .sum_o  (s),
        .cout_o (co)
      );
      assign busy[g] = bz;
      assign done[g] = dn;
      assign cout[g] = co;
      assign sum[g]  = 8'(s);
    end
  endgenerate

  // Reference result from plain integer arithmetic
  function automatic void ref_calc(input int w, input logic [7:0] av, input logic [7:0] bv,
                                   input bit ci, input bit sb,
                                   output logic [7:0] s, output bit co);
    longint mask;
    longint r;
    mask = (longint'(1) << w) - 1;
    if (!sb) r = (longint'(av) & mask) + (longint'(bv) & mask) + longint'(ci);
    else     r = (longint'(1) << w) + (longint'(av) & mask) - (longint'(bv) & mask) - longint'(ci);
    s  = 8'(r & mask);
    co = ((r >> w) & 1) != 0;
  endfunction

  bit         m_busy [NI];
  int         m_rem  [NI];
  bit         m_done [NI];
  logic [7:0] m_sum  [NI];
  bit         m_cout [NI];
  logic [7:0] p_sum  [NI];
  bit         p_cout [NI];

  // Transaction model: a result appears N edges after acceptance; a new request is
  // taken whenever no operation is outstanding or the outstanding one completes now.
  always @(posedge clk) begin
    bit was_busy;
    bit completing;
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_busy[k] = 1'b0;
        m_rem[k]  = 0;
        m_done[k] = 1'b0;
        m_sum[k]  = 8'h00;
        m_cout[k] = 1'b0;
      end else begin
        was_busy   = m_busy[k];
        completing = m_busy[k] && (m_rem[k] == 1);
        m_done[k]  = 1'b0;
        if (m_busy[k]) begin
          m_rem[k] = m_rem[k] - 1;
          if (m_rem[k] == 0) begin
            m_busy[k] = 1'b0;
            m_done[k] = 1'b1;
            m_sum[k]  = p_sum[k];
            m_cout[k] = p_cout[k];
          end
        end
        if (start && (!was_busy || completing)) begin
          ref_calc(CFG_W[k], a, b, cin, sub, p_sum[k], p_cout[k]);
          m_busy[k] = 1'b1;
          m_rem[k]  = CFG_W[k] / CFG_D[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (busy[k] !== m_busy[k] || done[k] !== m_done[k] ||
            sum[k] !== m_sum[k] || cout[k] !== m_cout[k]) begin
          n_errors++;
          $display("FAIL model[%0d] t=%0t busy/done/sum/cout got %b/%b/%h/%b expected %b/%b/%h/%b",
                   k, $time, busy[k], done[k], sum[k], cout[k],
                   m_busy[k], m_done[k], m_sum[k], m_cout[k]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic scramble();
    a   = 8'($urandom);
    b   = 8'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  // One start pulse, then record per-instance done latency over a bounded window
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input bit ci, input bit sb);
    @(negedge clk);
    a = av; b = bv; cin = ci; sub = sb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    for (int k = 0; k < NI; k++) lat[k] = -1;
    for (int c = 0; c <= 12; c++) begin
      for (int k = 0; k < NI; k++) if (lat[k] < 0 && done[k] === 1'b1) lat[k] = c;
      if (c < 12) @(negedge clk);
    end
  endtask

  task automatic check_op(input string name, input int k, input int exp_lat,
                          input logic [7:0] exp_sum, input bit exp_cout);
    check({name, "_latency"}, 32'(lat[k]), 32'(exp_lat));
    check({name, "_sum"}, 32'(sum[k]), 32'(exp_sum));
    check({name, "_cout"}, 32'(cout[k]), 32'(exp_cout));
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1; start = 1'b1; cin = 1'b0; sub = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    @(negedge clk);
    chk_en = 1'b1;
    scramble();
    @(negedge clk);
    check("reset_busy", 32'(busy[0]), 0);
    check("reset_done", 32'(done[0]), 0);
    check("reset_sum",  32'(sum[0]),  0);
    check("reset_cout", 32'(cout[0]), 0);
    rst = 1'b0; start = 1'b0;

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    check_op("add_d2", 0, 4, 8'h96, 1'b0);

    run_op(8'hFF, 8'h01, 1'b1, 1'b0);
    check_op("ovf_d2", 0, 4, 8'h01, 1'b1);
    check_op("ovf_d1", 1, 8, 8'h01, 1'b1);
    check_op("ovf_d8", 2, 1, 8'h01, 1'b1);

    run_op(8'h10, 8'h01, 1'b0, 1'b1);
    check_op("sub_nb_d2", 0, 4, 8'h0F, 1'b1);
    check_op("sub_nb_d8", 2, 1, 8'h0F, 1'b1);
    run_op(8'h00, 8'h01, 1'b0, 1'b1);
    check_op("sub_borrow_d2", 0, 4, 8'hFF, 1'b0);
    check_op("sub_borrow_d1", 1, 8, 8'hFF, 1'b0);
    run_op(8'h05, 8'h02, 1'b1, 1'b1);
    check_op("sub_bin_d2", 0, 4, 8'h02, 1'b1);

    // Handshake: ignored start mid-run, then back-to-back accept at the completion edge
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0; start = 1'b1;
    for (int t = 0; t <= 8; t++) begin
      @(negedge clk);
      if (t < 8) check($sformatf("hs_busy_t%0d", t), 32'(busy[0]), 1);
      case (t)
        0: begin start = 1'b0; scramble(); end
        1: begin start = 1'b1; a = 8'h77; b = 8'h01; cin = 1'b0; sub = 1'b0; end
        2: begin start = 1'b0; scramble(); end
        3: begin start = 1'b1; a = 8'h40; b = 8'h02; cin = 1'b0; sub = 1'b0; end
        4: begin
          check("hs_first_done", 32'(done[0]), 1);
          check("hs_first_sum",  32'(sum[0]),  32'h33);
          start = 1'b0; scramble();
        end
        5, 6, 7: begin
          check($sformatf("hs_hold_sum_t%0d", t), 32'(sum[0]), 32'h33);
          check($sformatf("hs_no_done_t%0d", t), 32'(done[0]), 0);
        end
        default: begin
          check("hs_second_done", 32'(done[0]), 1);
          check("hs_second_sum",  32'(sum[0]),  32'h42);
        end
      endcase
    end
    repeat (10) @(negedge clk);

    // Reset two edges into a run: no done may follow
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy[0]), 0);
    check("midrst_done", 32'(done[0]), 0);
    check("midrst_sum",  32'(sum[0]),  0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done[0] === 1'b1) saw_done = 1'b1;
    end
    check("midrst_no_done", 32'(saw_done), 0);
    run_op(8'h12, 8'h34, 1'b0, 1'b0);
    check_op("after_rst", 0, 4, 8'h46, 1'b0);

    // Exhaustive 4-bit sweep; 8-bit instances see the same low nibble with a random top
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++)
          for (int si = 0; si < 2; si++) begin
            @(negedge clk);
            a = {4'($urandom), 4'(ai)};
            b = {4'($urandom), 4'(bi)};
            cin = 1'(ci); sub = 1'(si); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (8) @(negedge clk);
          end

    // Random traffic with occasional resets
    repeat (2000) begin
      @(negedge clk);
      start = 1'($urandom);
      rst   = ($urandom % 50) == 0;
      scramble();
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
